// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier (low word) that borrows the shared ALU adder.
// Optional early termination when no multiplier bits remain: define ALU_MUL_EARLY_TERM_EN.
module alu_mul_seq #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [3:0]  ADD_CODE = 4'b0010,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_step;
  logic             last_iter;

  // Accumulator value after the current iteration; the ALU supplies acc + mcand.
  assign acc_step = mplier_q[0] ? alu_result : acc_q;

`ifdef ALU_MUL_EARLY_TERM_EN
  assign last_iter = (cnt_q == LastCnt) || (mplier_q[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt_q == LastCnt);
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    done     = 1'b0;
    alu_own  = 1'b0;
    alu_srcA = '0;
    alu_srcB = '0;
    alu_ctrl = 4'b0000;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        busy     = 1'b1;
        alu_own  = 1'b1;
        alu_srcA = acc_q;
        alu_srcB = mcand_q;
        alu_ctrl = ADD_CODE;
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          result_d = acc_step;
          state_d  = StDone;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq with a behavioural ALU beside it.
module tb_alu_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        alu_own;
  logic [31:0] alu_srcA;
  logic [31:0] alu_srcB;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;

  int n_checks;
  int n_errors;

`ifdef ALU_MUL_EARLY_TERM_EN
  localparam int RL7  = 3;
  localparam int RL6  = 3;
  localparam int RL5  = 3;
  localparam int RL0  = 1;
  localparam int RLFF = 32;
  localparam int RLZA = 17;
`else
  localparam int RL7  = 32;
  localparam int RL6  = 32;
  localparam int RL5  = 32;
  localparam int RL0  = 32;
  localparam int RLFF = 32;
  localparam int RLZA = 32;
`endif

  alu_mul_seq #(
    .WIDTH   (32),
    .ADD_CODE(4'b0010),
    .CNT_W   (5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .alu_own   (alu_own),
    .alu_srcA  (alu_srcA),
    .alu_srcB  (alu_srcB),
    .alu_ctrl  (alu_ctrl),
    .alu_result(alu_result)
  );

  // Shared ALU: only the ADD code adds; anything else subtracts so a wrong code shows up.
  assign alu_result = (alu_ctrl == 4'b0010) ? alu_srcA + alu_srcB : alu_srcA - alu_srcB;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one operation from IDLE and measures it; returns in the cycle after DONE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int own_cnt, output int done_idx, output int done_w,
                        output logic [31:0] res, output bit ctrl_ok,
                        output logic [31:0] srcb1, output logic [31:0] srcb2);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    tick();
    start    = 1'b0;
    own_cnt  = 0;
    done_idx = -1;
    done_w   = 0;
    ctrl_ok  = 1'b1;
    res      = 'x;
    srcb1    = 'x;
    srcb2    = 'x;
    for (int idx = 1; idx <= 80; idx++) begin
      if (alu_own) begin
        own_cnt++;
        if (alu_ctrl !== 4'b0010) ctrl_ok = 1'b0;
      end else if (alu_ctrl !== 4'd0 || alu_srcA !== 32'd0 || alu_srcB !== 32'd0) begin
        ctrl_ok = 1'b0;
      end
      if (idx == 1) srcb1 = alu_srcB;
      if (idx == 2) srcb2 = alu_srcB;
      if (done === 1'b1) begin
        if (done_idx < 0) begin
          done_idx = idx;
          res      = result;
        end
        done_w++;
      end else if (done_idx > 0) begin
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_busy_done: got busy=%b done=%b, expected 0 0", busy, done);
    end
    n_checks++;
    if (result !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_result: got %h, expected 00000000", result);
    end
    n_checks++;
    if (alu_own !== 1'b0 || alu_ctrl !== 4'd0 || alu_srcA !== 32'd0 || alu_srcB !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_alu: got own=%b ctrl=%h a=%h b=%h, expected all 0",
               alu_own, alu_ctrl, alu_srcA, alu_srcB);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int own_cnt, done_idx, done_w;
    logic [31:0] res, sb1, sb2;
    bit ok;
    run_op(32'd6, 32'd7, own_cnt, done_idx, done_w, res, ok, sb1, sb2);
    n_checks++;
    if (own_cnt !== RL7) begin
      n_errors++;
      $display("FAIL basic_own_cycles: got %0d, expected %0d", own_cnt, RL7);
    end
    n_checks++;
    if (done_idx !== RL7 + 1) begin
      n_errors++;
      $display("FAIL basic_done_latency: got %0d, expected %0d", done_idx, RL7 + 1);
    end
    n_checks++;
    if (done_w !== 1) begin
      n_errors++;
      $display("FAIL basic_done_width: got %0d, expected 1", done_w);
    end
    n_checks++;
    if (res !== 32'd42) begin
      n_errors++;
      $display("FAIL basic_result: got %h, expected 0000002a", res);
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_alu_ctrl: got ok=%b, expected 1", ok);
    end
    n_checks++;
    if (sb1 !== 32'd6 || sb2 !== 32'd12) begin
      n_errors++;
      $display("FAIL basic_srcB_shift: got %h %h, expected 00000006 0000000c", sb1, sb2);
    end
    n_checks++;
    if (busy !== 1'b0 || result !== 32'd42) begin
      n_errors++;
      $display("FAIL basic_after_done: got busy=%b result=%h, expected 0 0000002a", busy, result);
    end
  endtask

  task automatic test_wrap;
    int own_cnt, done_idx, done_w;
    logic [31:0] res, sb1, sb2;
    bit ok;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, own_cnt, done_idx, done_w, res, ok, sb1, sb2);
    n_checks++;
    if (res !== 32'h0000_0001 || done_idx !== RLFF + 1) begin
      n_errors++;
      $display("FAIL wrap_all_ones: got %h at %0d, expected 00000001 at %0d",
               res, done_idx, RLFF + 1);
    end
    run_op(32'hFFFF_FFFD, 32'd5, own_cnt, done_idx, done_w, res, ok, sb1, sb2);
    n_checks++;
    if (res !== 32'hFFFF_FFF1 || done_idx !== RL5 + 1) begin
      n_errors++;
      $display("FAIL wrap_neg3_x5: got %h at %0d, expected fffffff1 at %0d",
               res, done_idx, RL5 + 1);
    end
  endtask

  task automatic test_zero_and_short;
    int own_cnt, done_idx, done_w;
    logic [31:0] res, sb1, sb2;
    bit ok;
    run_op(32'd7, 32'd6, own_cnt, done_idx, done_w, res, ok, sb1, sb2);
    n_checks++;
    if (res !== 32'd42 || own_cnt !== RL6 || done_idx !== RL6 + 1) begin
      n_errors++;
      $display("FAIL short_7x6: got %h own=%0d done=%0d, expected 0000002a own=%0d done=%0d",
               res, own_cnt, done_idx, RL6, RL6 + 1);
    end
    run_op(32'h1234_5678, 32'd0, own_cnt, done_idx, done_w, res, ok, sb1, sb2);
    n_checks++;
    if (res !== 32'd0 || own_cnt !== RL0 || done_idx !== RL0 + 1) begin
      n_errors++;
      $display("FAIL zero_op_b: got %h own=%0d done=%0d, expected 00000000 own=%0d done=%0d",
               res, own_cnt, done_idx, RL0, RL0 + 1);
    end
    run_op(32'd0, 32'h0001_2345, own_cnt, done_idx, done_w, res, ok, sb1, sb2);
    n_checks++;
    if (res !== 32'd0 || done_idx !== RLZA + 1) begin
      n_errors++;
      $display("FAIL zero_op_a: got %h done=%0d, expected 00000000 done=%0d",
               res, done_idx, RLZA + 1);
    end
  endtask

  // 7 * 0x80000006 = 0x8000002a (mod 2^32); top multiplier bit keeps RUN at 32 cycles.
  task automatic test_ignored_start;
    int done_idx;
    done_idx = -1;
    start = 1'b1;
    op_a  = 32'd7;
    op_b  = 32'h8000_0006;
    tick();
    start = 1'b0;
    for (int idx = 1; idx <= 60; idx++) begin
      if (idx == 5) begin
        start = 1'b1;
        op_a  = 32'd3;
        op_b  = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        done_idx = idx;
        break;
      end
      tick();
    end
    n_checks++;
    if (done_idx !== 33 || result !== 32'h8000_002A) begin
      n_errors++;
      $display("FAIL busy_start_ignored: got %h at %0d, expected 8000002a at 33",
               result, done_idx);
    end
    start = 1'b1;
    op_a  = 32'd9;
    op_b  = 32'd9;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h8000_002A) begin
      n_errors++;
      $display("FAIL done_start_ignored: got busy=%b done=%b result=%h, expected 0 0 8000002a",
               busy, done, result);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL done_start_no_run: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int first_done, idle_idx, second_done;
    first_done  = -1;
    idle_idx    = -1;
    second_done = -1;
    start = 1'b1;
    op_a  = 32'd6;
    op_b  = 32'd7;
    tick();
    for (int idx = 1; idx <= 100; idx++) begin
      if (done === 1'b1) begin
        if (first_done < 0) first_done = idx;
        else if (second_done < 0) second_done = idx;
      end
      if (first_done > 0 && idle_idx < 0 && busy === 1'b0) idle_idx = idx;
      if (second_done > 0) break;
      tick();
    end
    start = 1'b0;
    n_checks++;
    if (first_done !== RL7 + 1 || idle_idx !== RL7 + 2) begin
      n_errors++;
      $display("FAIL b2b_first: got done=%0d idle=%0d, expected done=%0d idle=%0d",
               first_done, idle_idx, RL7 + 1, RL7 + 2);
    end
    n_checks++;
    if (second_done !== 2 * RL7 + 3 || result !== 32'd42) begin
      n_errors++;
      $display("FAIL b2b_second: got done=%0d result=%h, expected done=%0d result=0000002a",
               second_done, result, 2 * RL7 + 3);
    end
    tick();
  endtask

  task automatic test_reset_mid_run;
    int stray_done;
    stray_done = 0;
    start = 1'b1;
    op_a  = 32'd7;
    op_b  = 32'h8000_0006;
    tick();
    start = 1'b0;
    for (int idx = 1; idx < 10; idx++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || alu_own !== 1'b0 || result !== 32'd0 || alu_ctrl !== 4'd0 ||
        alu_srcA !== 32'd0 || alu_srcB !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_mid_run: got busy=%b own=%b result=%h ctrl=%h, expected 0 0 0 0",
               busy, alu_own, result, alu_ctrl);
    end
    for (int idx = 0; idx < 40; idx++) begin
      if (done === 1'b1 || busy === 1'b1) stray_done++;
      tick();
    end
    n_checks++;
    if (stray_done !== 0) begin
      n_errors++;
      $display("FAIL reset_no_done: got %0d active cycles, expected 0", stray_done);
    end
  endtask

  task automatic test_reset_and_start;
    reset = 1'b1;
    start = 1'b1;
    op_a  = 32'd5;
    op_b  = 32'd5;
    tick();
    reset = 1'b0;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || alu_own !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_beats_start: got busy=%b own=%b, expected 0 0", busy, alu_own);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_start_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op_a     = '0;
    op_b     = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_and_short();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    test_reset_and_start();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
